pc_sequencer: RTL and testbench

//  Consumer side of the execute-stage branch decision: takes the taken-branch and

---
 rtl/pc_sequencer_pkg.sv | 13 +
 rtl/pc_target_calc.sv | 23 ++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-PC sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PCS_RUN   = 2'd0,
    PCS_FLUSH = 2'd1,
    PCS_DRAIN = 2'd2,
    PCS_HALT  = 2'd3
  } pcs_state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target adder: branch/JAL use pc+imm, JALR uses (rs1+imm) with bit 0 cleared.
module pc_target_calc #(
  parameter int XLEN = 32
) (
  input  logic            jalr,
  input  logic            branch,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base     = jalr ? rs1 : pc;
  assign sum      = base + imm;
  assign target   = jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  // Only a taken redirect can fault; bit 1 set means not word aligned.
  assign misalign = branch & target[1];

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural fetch PC: sequential advance, branch redirect,
// FENCE drain-and-refetch, ECALL/EBREAK and misaligned-target halt with resume.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic            ex_jalr_i,
  input  logic            ex_ecall_i,
  input  logic            ex_fence_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic            mem_idle_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic            if_valid_o,
  output logic            flush_o,
  output logic            halted_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] epc_o,
  output logic [1:0]      state_o
);

  localparam int              CW       = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] INC      = XLEN'(PC_INC);

  pcs_state_e      state, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] epc_q, epc_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            mis_q, mis_n;
  logic [XLEN-1:0] target;
  logic            tgt_mis;
  logic            accept;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .jalr     (ex_jalr_i),
    .branch   (ex_branch_i),
    .pc       (ex_pc_i),
    .imm      (ex_imm_i),
    .rs1      (ex_rs1_i),
    .target   (target),
    .misalign (tgt_mis)
  );

  // EX handshake: ex_valid_i is a qualifier with no back-pressure; an event is
  // consumed in exactly the cycle state==RUN and ex_valid_i=1, and dropped otherwise.
  assign accept = (state == PCS_RUN) && ex_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PCS_RUN;
      pc_q  <= RESET_PC;
      epc_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      epc_q <= epc_n;
      cnt_q <= cnt_n;
      mis_q <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    epc_n   = epc_q;
    cnt_n   = cnt_q;
    mis_n   = mis_q;
    case (state)
      PCS_RUN: begin
        if (accept && ex_ecall_i) begin
          epc_n   = ex_pc_i;
          state_n = PCS_HALT;
        end else if (accept && tgt_mis) begin
          epc_n   = ex_pc_i;
          mis_n   = 1'b1;
          state_n = PCS_HALT;
        end else if (accept && ex_branch_i) begin
          pc_n    = target;
          cnt_n   = CNT_INIT;
          state_n = PCS_FLUSH;
        end else if (accept && ex_fence_i) begin
          epc_n   = ex_pc_i;
          state_n = PCS_DRAIN;
        end else if (!stall_i) begin
          pc_n = pc_q + INC;
        end
      end
      PCS_FLUSH: begin
        // Counter holds bubbles remaining after this one.
        pc_n = pc_q + INC;
        if (cnt_q == '0) state_n = PCS_RUN;
        else             cnt_n   = cnt_q - CW'(1);
      end
      PCS_DRAIN: begin
        if (mem_idle_i) begin
          pc_n    = epc_q + INC;
          cnt_n   = CNT_INIT;
          state_n = PCS_FLUSH;
        end
      end
      PCS_HALT: begin
        if (resume_i) begin
          pc_n    = epc_q + INC;
          mis_n   = 1'b0;
          cnt_n   = CNT_INIT;
          state_n = PCS_FLUSH;
        end
      end
      default: state_n = PCS_RUN;
    endcase
  end

  always_comb begin
    pc_o       = pc_q;
    epc_o      = epc_q;
    misalign_o = mis_q;
    if_valid_o = (state == PCS_RUN);
    halted_o   = (state == PCS_HALT);
    flush_o    = accept && (ex_ecall_i || ex_branch_i || ex_fence_i);
    state_o    = state;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus randomized EX traffic.
module tb_pc_sequencer;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk, rst_n;
  logic            stall_i, ex_valid_i, ex_branch_i, ex_jalr_i, ex_ecall_i, ex_fence_i;
  logic [XLEN-1:0] ex_pc_i, ex_imm_i, ex_rs1_i;
  logic            mem_idle_i, resume_i;
  logic [XLEN-1:0] pc_o, epc_o;
  logic            if_valid_o, flush_o, halted_o, misalign_o;
  logic [1:0]      state_o;

  pc_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
    .ex_branch_i(ex_branch_i), .ex_jalr_i(ex_jalr_i), .ex_ecall_i(ex_ecall_i),
    .ex_fence_i(ex_fence_i), .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .ex_rs1_i(ex_rs1_i),
    .mem_idle_i(mem_idle_i), .resume_i(resume_i), .pc_o(pc_o), .if_valid_o(if_valid_o),
    .flush_o(flush_o), .halted_o(halted_o), .misalign_o(misalign_o), .epc_o(epc_o),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: bubbles = fetch cycles still to be discarded
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        iv;
    logic        fl;
    logic        ha;
    logic        mi;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_pc, m_epc;
  bit          m_halt, m_drain, m_mis;
  int          m_bub;

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0;
    m_halt = 0; m_drain = 0; m_mis = 0; m_bub = 0;
  endtask

  function automatic logic [31:0] ref_target(input bit jalr, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [31:0] rs1);
    longint unsigned s;
    logic [31:0] t;
    s = jalr ? (longint'(rs1) + longint'(imm)) : (longint'(pc) + longint'(imm));
    t = 32'(s % 64'h1_0000_0000);
    if (jalr) t = t & 32'hFFFF_FFFE;
    return t;
  endfunction

  task automatic model_step(input bit v, br, jr, ec, fe, st, idle, res,
                            input logic [31:0] pc, imm, rs1);
    exp_t e;
    bit running;
    logic [31:0] t;
    running = !m_halt && !m_drain && (m_bub == 0);
    t = ref_target(jr, pc, imm, rs1);
    e.pc = m_pc; e.epc = m_epc; e.iv = running; e.ha = m_halt; e.mi = m_mis;
    e.fl = running && v && (ec || br || fe);
    exp_q.push_back(e);
    if (running) begin
      if (v && ec) begin m_epc = pc; m_halt = 1; end
      else if (v && br && t[1]) begin m_epc = pc; m_mis = 1; m_halt = 1; end
      else if (v && br) begin m_pc = t; m_bub = FC; end
      else if (v && fe) begin m_epc = pc; m_drain = 1; end
      else if (!st) m_pc = m_pc + 32'd4;
    end else if (m_bub > 0) begin
      m_pc = m_pc + 32'd4; m_bub--;
    end else if (m_drain) begin
      if (idle) begin m_pc = m_epc + 32'd4; m_drain = 0; m_bub = FC; end
    end else if (m_halt) begin
      if (res) begin m_pc = m_epc + 32'd4; m_mis = 0; m_halt = 0; m_bub = FC; end
    end
  endtask

  // driver tasks
  task automatic drive(input bit v, br, jr, ec, fe, st, idle, res,
                       input logic [31:0] pc, imm, rs1);
    @(negedge clk);
    ex_valid_i = v; ex_branch_i = br; ex_jalr_i = jr; ex_ecall_i = ec; ex_fence_i = fe;
    stall_i = st; mem_idle_i = idle; resume_i = res;
    ex_pc_i = pc; ex_imm_i = imm; ex_rs1_i = rs1;
    model_step(v, br, jr, ec, fe, st, idle, res, pc, imm, rs1);
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {stall_i, ex_valid_i, ex_branch_i, ex_jalr_i, ex_ecall_i, ex_fence_i} = '0;
    {mem_idle_i, resume_i} = '0;
    ex_pc_i = '0; ex_imm_i = '0; ex_rs1_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // monitor: compare every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc", pc_o, e.pc);
        check("sb_epc", epc_o, e.epc);
        check("sb_if_valid", if_valid_o, e.iv);
        check("sb_flush", flush_o, e.fl);
        check("sb_halted", halted_o, e.ha);
        check("sb_misalign", misalign_o, e.mi);
      end
    end
  end

  initial begin
    bit v, br, jr, ec, fe, st, idl, res;
    logic [31:0] rpc, rimm, rrs1;
    rst_n = 1'b0;
    do_reset();
    check("reset_pc", pc_o, 32'h0);
    check("reset_if_valid", if_valid_o, 1);
    check("reset_flush", flush_o, 0);
    check("reset_halted", halted_o, 0);
    check("reset_misalign", misalign_o, 0);
    check("reset_epc", epc_o, 32'h0);

    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      check("seq_pc", pc_o, 32'(i * 4));
      check("seq_if_valid", if_valid_o, 1);
    end

    // branch 0x10 + 0x20
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h10, 32'h20, 32'h0);
    check("br_flush", flush_o, 1);
    idle_cycle(); check("br_pc", pc_o, 32'h30); check("br_bubble1", if_valid_o, 0);
    idle_cycle(); check("br_pc2", pc_o, 32'h34); check("br_bubble2", if_valid_o, 0);
    idle_cycle(); check("br_run", if_valid_o, 1); check("br_pc3", pc_o, 32'h38);

    // JALR aligned then misaligned
    drive(1, 1, 1, 0, 0, 0, 0, 0, 32'h50, 32'h4, 32'h101);
    idle_cycle(); check("jalr_pc", pc_o, 32'h104);
    idle_cycle();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 32'h200, 32'h0, 32'h102);
    check("mis_flush", flush_o, 1);
    idle_cycle();
    check("mis_halted", halted_o, 1); check("mis_flag", misalign_o, 1);
    check("mis_epc", epc_o, 32'h200);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    idle_cycle();
    check("resume_pc", pc_o, 32'h204); check("resume_mis_clr", misalign_o, 0);
    check("resume_halted", halted_o, 0);
    idle_cycle();

    // FENCE, memory busy three cycles
    drive(1, 0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0);
    check("fence_flush", flush_o, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
      check("drain_hold_pc", pc_o, 32'h20C); check("drain_if_valid", if_valid_o, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    idle_cycle(); check("fence_refetch", pc_o, 32'h44); check("fence_bubble", if_valid_o, 0);
    idle_cycle();

    // ECALL under stall; EX traffic while halted is ignored
    drive(1, 0, 0, 1, 0, 1, 0, 0, 32'h80, 32'h0, 32'h0);
    check("ecall_flush", flush_o, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0, 1, 1, 0, 32'h90, 32'h100, 32'h0);
      check("halt_hold_pc", pc_o, 32'h4C); check("halt_flag", halted_o, 1);
      check("halt_no_flush", flush_o, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    idle_cycle(); check("ecall_resume_pc", pc_o, 32'h84); check("ecall_bubble", if_valid_o, 0);
    idle_cycle();
    idle_cycle(); check("ecall_run", if_valid_o, 1); check("ecall_run_pc", pc_o, 32'h8C);

    // async reset mid-FLUSH
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h100, 32'h100, 32'h0);
    idle_cycle(); check("pre_rst_flush", if_valid_o, 0);
    #2 rst_n = 1'b0;
    #1 check("rst_flush_pc", pc_o, 32'h0); check("rst_flush_iv", if_valid_o, 1);
    check("rst_flush_halted", halted_o, 0);
    do_reset();

    // async reset mid-HALT
    drive(1, 0, 0, 1, 0, 0, 0, 0, 32'h300, 32'h0, 32'h0);
    idle_cycle(); check("pre_rst_halt", halted_o, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_halt_pc", pc_o, 32'h0); check("rst_halt_halted", halted_o, 0);
    check("rst_halt_iv", if_valid_o, 1); check("rst_halt_epc", epc_o, 32'h0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 5) == 0);
      jr  = br && ($urandom_range(0, 2) == 0);
      ec  = ($urandom_range(0, 29) == 0);
      fe  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 3) == 0);
      idl = ($urandom_range(0, 2) == 0);
      res = ($urandom_range(0, 3) == 0);
      rpc  = $urandom() & 32'hFFFF_FFFC;
      rimm = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      rrs1 = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      drive(v, br, jr, ec, fe, st, idl, res, rpc, rimm, rrs1);
    end

    idle_cycle();
    @(negedge clk);
    #3 check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
